axi4l_param_reg_file: RTL and testbench
=======================================

// Module: axi4l_param_reg_file
// PURPOSE
//  Parametrised AXI4-Lite slave register file; successor to the fixed 4-register, 32-bit axi4l_reg_file.
//  Configurable data width and register count. Top NUM_RO registers are read-only status inputs.
//  Per-register write pulses. SLVERR on out-of-range or read-only access.
//  Sits behind the Xilinx-facing S_AXI_* wrapper; fabric logic consumes o_regs / o_wr_pulse.
// PARAMETERS
//  DATA_WIDTH   32  bus/register width; 32 or 64; strobe width DATA_WIDTH/8
//  ADDR_WIDTH   6   byte address width; requires NUM_REGS <= 2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
//  NUM_REGS     8   total registers, indices 0..NUM_REGS-1
//  NUM_RO       2   indices NUM_REGS-NUM_RO..NUM_REGS-1 are read-only; 0 <= NUM_RO <= NUM_REGS
//  RESET_VALUE  0   reset value of every RW register
// PORTS
//  i_axi_clock         in   1                  single clock, all logic rising-edge
//  i_axi_aresetn       in   1                  synchronous, active-low reset
//  i_axi_awaddr        in   ADDR_WIDTH         write address
//  i_axi_awprot        in   3                  ignored
//  i_axi_awaddr_valid  in   1                  AW valid
//  o_axi_awaddr_ready  out  1                  AW ready
//  i_axi_wdata         in   DATA_WIDTH         write data
//  i_axi_wstrb         in   DATA_WIDTH/8       byte strobes
//  i_axi_wdata_valid   in   1                  W valid
//  o_axi_wdata_ready   out  1                  W ready
//  o_axi_bresp         out  2                  2'b00 OKAY / 2'b10 SLVERR
//  o_axi_bvalid        out  1                  B valid
//  i_axi_bready        in   1                  B ready
//  i_axi_araddr        in   ADDR_WIDTH         read address
//  i_axi_arcache       in   4                  ignored
//  i_axi_arprot        in   3                  ignored
//  i_axi_araddr_valid  in   1                  AR valid
//  o_axi_araddr_ready  out  1                  AR ready
//  o_axi_rdata         out  DATA_WIDTH         read data
//  o_axi_rresp         out  2                  2'b00 OKAY / 2'b10 SLVERR
//  o_axi_rdata_valid   out  1                  R valid
//  i_axi_rdata_ready   in   1                  R ready
//  o_regs              out  NUM_REGS*DATA_WIDTH  RW register contents, index i at [i*DATA_WIDTH +: DATA_WIDTH]
//                                              RO slots drive 0
//  o_wr_pulse          out  NUM_REGS           1-cycle strobe per committed write
//  i_status            in   NUM_RO*DATA_WIDTH  RO values; slice k = index NUM_REGS-NUM_RO+k
// BEHAVIOUR
//  Reset (i_axi_aresetn=0 at an edge):
//   - All readies, bvalid and rvalid go 0; bresp/rresp/rdata go 0.
//   - RW regs go RESET_VALUE; o_wr_pulse goes 0.
//   - Pending AW/W/AR latches are discarded; no response is ever issued for them.
//   - Readies rise on the first edge with reset high.
//  Decode: idx = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte bits ignored.
//  Write channels are independent. AW and W each have a one-entry holding latch.
//   - awready = !aw_full; wready = !w_full. Either channel may arrive first, any gap.
//  Commit: when aw_full & w_full & (!bvalid | bready):
//   - On that edge, RW target bytes with strb=1 are written and bvalid=1 with bresp.
//   - Both latches clear, so bvalid is high 1 cycle after both latches are full.
//   - o_wr_pulse[idx]=1 for exactly that cycle only if idx is RW and strb!=0.
//   - idx>=NUM_REGS or idx is RO: SLVERR, no write, no pulse. strb==0 on RW: OKAY, no change.
//  B channel: bvalid/bresp are held until bready. A second AW+W pair may be latched meanwhile,
//   but it does not commit until B is accepted (a commit on the B-accept edge is allowed).
//  Read: arready = !rvalid (registered).
//   - The AR handshake edge loads rdata/rresp and sets rvalid (1-cycle latency).
//   - rvalid held and rdata stable until rready; arready returns high after the R-accept edge.
//   - RO index returns i_status sampled at the AR edge.
//   - idx>=NUM_REGS: rdata 0, SLVERR.
//  Same-edge read and commit to one register: the read returns the pre-write value.
//  Read and write paths are otherwise fully concurrent.
// TESTING
//  T1 Reset: aresetn=0 for 3 edges mid-write -> bvalid=0, all o_regs=0, readies 0.
//     Then readies=1 one edge after release.
//  T2 Strobes: write 0xDEADBEEF strb 4'hF to 0x04, then 0x12345678 strb 4'h3 with AW 3 cycles before W.
//     -> reg1=0xDEAD5678, BRESP 00 each, o_wr_pulse[1] high 1 cycle each.
//  T3 Backpressure: bready=0 for 5 cycles over two writes -> first bvalid held.
//     Second pair latched, awready=wready=0, reg unchanged until B accepted.
//     Then second commit on the accept edge.
//  T4 Out-of-range: write 0x3C (idx 15) -> BRESP 2'b10, no reg/pulse change.
//     Read 0x3C -> RDATA 0, RRESP 2'b10.
//  T5 RO: i_status[63:32]=0xCAFEF00D; write 0x1C -> SLVERR, no pulse.
//     Read 0x1C -> RDATA 0xCAFEF00D, RRESP 00.
//  T6 Collision/stall: read 0x08 on the commit edge of write 0xA5A5A5A5 to 0x08 -> RDATA old value.
//     rready=0 4 cycles -> rvalid/rdata stable, arready=0.

Source files
------------

// File: rtl/axi4l_param_reg_file.sv
// AXI4-Lite slave register file with configurable width and depth.
// The upper NUM_RO slots read back live status inputs; writes to them are rejected.
module axi4l_param_reg_file #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    NUM_REGS    = 8,
  parameter int                    NUM_RO      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                  i_axi_clock,
  input  logic                                  i_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]                 i_axi_awaddr,
  input  logic [2:0]                            i_axi_awprot,
  input  logic                                  i_axi_awaddr_valid,
  output logic                                  o_axi_awaddr_ready,
  input  logic [DATA_WIDTH-1:0]                 i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]               i_axi_wstrb,
  input  logic                                  i_axi_wdata_valid,
  output logic                                  o_axi_wdata_ready,
  output logic [1:0]                            o_axi_bresp,
  output logic                                  o_axi_bvalid,
  input  logic                                  i_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                 i_axi_araddr,
  input  logic [3:0]                            i_axi_arcache,
  input  logic [2:0]                            i_axi_arprot,
  input  logic                                  i_axi_araddr_valid,
  output logic                                  o_axi_araddr_ready,
  output logic [DATA_WIDTH-1:0]                 o_axi_rdata,
  output logic [1:0]                            o_axi_rresp,
  output logic                                  o_axi_rdata_valid,
  input  logic                                  i_axi_rdata_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]        o_regs,
  output logic [NUM_REGS-1:0]                   o_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] i_status
);

  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int         LSB         = $clog2(STRB_WIDTH);
  localparam int         IDX_WIDTH   = ADDR_WIDTH - LSB;
  localparam int         NUM_RW      = NUM_REGS - NUM_RO;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_full_q, aw_full_d;
  logic [IDX_WIDTH-1:0]  aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, aw_is_rw_s, ar_in_range_s;
  logic [IDX_WIDTH-1:0]  ar_idx_s;
  logic [DATA_WIDTH-1:0] rd_src_s [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_s;

  function automatic logic idx_below(input logic [IDX_WIDTH-1:0] idx, input int limit);
    return int'(idx) < limit;
  endfunction

  assign aw_hs_s       = i_axi_awaddr_valid & awready_q;
  assign w_hs_s        = i_axi_wdata_valid & wready_q;
  assign ar_hs_s       = i_axi_araddr_valid & arready_q;
  assign ar_idx_s      = i_axi_araddr[ADDR_WIDTH-1:LSB];
  assign aw_is_rw_s    = idx_below(aw_idx_q, NUM_RW);
  assign ar_in_range_s = idx_below(ar_idx_s, NUM_REGS);
  assign commit_s      = aw_full_q & w_full_q & (~bvalid_q | i_axi_bready);

  // Holding latches empty on commit; they can only refill while empty, so no conflict.
  assign aw_full_d = commit_s ? 1'b0 : (aw_full_q | aw_hs_s);
  assign aw_idx_d  = aw_hs_s ? i_axi_awaddr[ADDR_WIDTH-1:LSB] : aw_idx_q;
  assign w_full_d  = commit_s ? 1'b0 : (w_full_q | w_hs_s);
  assign w_data_d  = w_hs_s ? i_axi_wdata : w_data_q;
  assign w_strb_d  = w_hs_s ? i_axi_wstrb : w_strb_q;
  assign awready_d = ~aw_full_d;
  assign wready_d  = ~w_full_d;
  assign bvalid_d  = commit_s ? 1'b1 : (bvalid_q & ~i_axi_bready);
  assign bresp_d   = commit_s ? (aw_is_rw_s ? RESP_OKAY : RESP_SLVERR) : bresp_q;

  assign rvalid_d  = ar_hs_s ? 1'b1 : (rvalid_q & ~i_axi_rdata_ready);
  assign arready_d = ~rvalid_d;
  assign rdata_d   = ar_hs_s ? (ar_in_range_s ? rd_word_s : '0) : rdata_q;
  assign rresp_d   = ar_hs_s ? (ar_in_range_s ? RESP_OKAY : RESP_SLVERR) : rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
    if (g < NUM_RW) begin : g_rw
      assign rd_src_s[g]                        = regs_q[g];
      assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end else begin : g_ro
      assign rd_src_s[g]                        = i_status[(g-NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
      assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  // Read mux over all slots; reads see the pre-commit register value.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = rd_word_s | ((int'(ar_idx_s) == i) ? rd_src_s[i] : '0);
    end
  end

  // Byte-lane merge and write pulse for the committed RW target.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        regs_d[i][b*8 +: 8] = (commit_s && (int'(aw_idx_q) == i) && w_strb_q[b]) ?
                              w_data_q[b*8 +: 8] : regs_q[i][b*8 +: 8];
      end
      wr_pulse_d[i] = commit_s && (int'(aw_idx_q) == i) && (|w_strb_q);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_axi_clock) begin
    if (!i_axi_aresetn) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i < NUM_RW) ? RESET_VALUE : '0;
      end
    end else begin
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign o_axi_awaddr_ready = awready_q;
  assign o_axi_wdata_ready  = wready_q;
  assign o_axi_bvalid       = bvalid_q;
  assign o_axi_bresp        = bresp_q;
  assign o_axi_araddr_ready = arready_q;
  assign o_axi_rdata_valid  = rvalid_q;
  assign o_axi_rdata        = rdata_q;
  assign o_axi_rresp        = rresp_q;
  assign o_wr_pulse         = wr_pulse_q;

  assign unused_s = ^{i_axi_awprot, i_axi_arprot, i_axi_arcache,
                      i_axi_awaddr[LSB-1:0], i_axi_araddr[LSB-1:0]};

endmodule

// File: tb/tb_axi4l_param_reg_file.sv
// Bench for axi4l_param_reg_file: table of single transactions plus hand-built
// sequences for reset, B backpressure and read/commit collision.
module tb_axi4l_param_reg_file;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NR  = 8;
  localparam int NRO = 2;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0]        o_bresp, o_rresp;
  logic [DW-1:0]     o_rdata;
  logic [NR*DW-1:0]  o_regs;
  logic [NR-1:0]     o_wr_pulse;
  logic [NRO*DW-1:0] status;

  axi4l_param_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_RO(NRO),
                         .RESET_VALUE(32'h0000_0000)) dut (
    .i_axi_clock(clk), .i_axi_aresetn(aresetn),
    .i_axi_awaddr(awaddr), .i_axi_awprot(3'b000), .i_axi_awaddr_valid(awvalid),
    .o_axi_awaddr_ready(o_awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wdata_valid(wvalid),
    .o_axi_wdata_ready(o_wready),
    .o_axi_bresp(o_bresp), .o_axi_bvalid(o_bvalid), .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arcache(4'h0), .i_axi_arprot(3'b000),
    .i_axi_araddr_valid(arvalid), .o_axi_araddr_ready(o_arready),
    .o_axi_rdata(o_rdata), .o_axi_rresp(o_rresp), .o_axi_rdata_valid(o_rvalid),
    .i_axi_rdata_ready(rready),
    .o_regs(o_regs), .o_wr_pulse(o_wr_pulse), .i_status(status)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] model[NR];
  int          pulse_cnt[NR];
  int          exp_pulse[NR];

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;   // >0: AW leads W by N cycles, <0: W leads AW
    logic [1:0]  resp;
    logic [31:0] val;    // write: new register value; read: expected rdata
    int          pidx;   // register expected to pulse, -1 for none
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [NR*DW-1:0] e;
    e = '0;
    for (int i = 0; i < NR - NRO; i++) e[i*DW +: DW] = model[i];
    checks++;
    if (o_regs !== e) begin
      errors++;
      $display("FAIL %s: o_regs actual=%h expected=%h", name, o_regs, e);
    end
  endtask

  task automatic check_pulses(input string name);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < NR; i++) if (pulse_cnt[i] != exp_pulse[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: pulse counts actual=%p expected=%p", name, pulse_cnt, exp_pulse);
    end
  endtask

  // Scoreboard: responses are compared as they are handshaken.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (o_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    if (o_bvalid === 1'b1 && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 64'(o_bvalid), 64'(0));
      else check("bresp", 64'(o_bresp), 64'(exp_b.pop_front()));
    end
    if (o_rvalid === 1'b1 && rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 64'(o_rvalid), 64'(0));
      else check("rdata_rresp", 64'({o_rdata, o_rresp}), 64'(exp_r.pop_front()));
    end
  end

  task automatic aw_send(input logic [5:0] a);
    bit done = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); done = o_awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(done), 64'(1));
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bit done = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); done = o_wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    check("w_handshake", 64'(done), 64'(1));
  endtask

  task automatic ar_send(input logic [5:0] a);
    bit done = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); done = o_arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    check("ar_handshake", 64'(done), 64'(1));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_drain"}, 64'(exp_b.size() + exp_r.size()), 64'(0));
    exp_b.delete();
    exp_r.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 0,  2'b00, 32'hDEADBEEF, 1};
    vecs[1]  = '{1'b1, 6'h04, 32'h12345678, 4'h3, 3,  2'b00, 32'hDEAD5678, 1};
    vecs[2]  = '{1'b1, 6'h00, 32'hA1B2C3D4, 4'h4, 0,  2'b00, 32'h00B20000, 0};
    vecs[3]  = '{1'b1, 6'h08, 32'hFFFFFFFF, 4'h0, 0,  2'b00, 32'h00000000, -1};
    vecs[4]  = '{1'b1, 6'h3C, 32'h55555555, 4'hF, 0,  2'b10, 32'h00000000, -1};
    vecs[5]  = '{1'b1, 6'h1C, 32'h77777777, 4'hF, -2, 2'b10, 32'h00000000, -1};
    vecs[6]  = '{1'b0, 6'h04, 32'h0,        4'h0, 0,  2'b00, 32'hDEAD5678, -1};
    vecs[7]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 0,  2'b10, 32'h00000000, -1};
    vecs[8]  = '{1'b0, 6'h1C, 32'h0,        4'h0, 0,  2'b00, 32'hCAFEF00D, -1};
    vecs[9]  = '{1'b0, 6'h18, 32'h0,        4'h0, 0,  2'b00, 32'h11223344, -1};
    vecs[10] = '{1'b0, 6'h01, 32'h0,        4'h0, 0,  2'b00, 32'h00B20000, -1};
    vecs[11] = '{1'b1, 6'h16, 32'h87654321, 4'hF, -3, 2'b00, 32'h87654321, 5};
    vecs[12] = '{1'b0, 6'h14, 32'h0,        4'h0, 0,  2'b00, 32'h87654321, -1};

    aresetn = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    status = {32'hCAFEF00D, 32'h11223344};
    for (int i = 0; i < NR; i++) begin model[i] = 32'h0; exp_pulse[i] = 0; end

    // Power-on reset
    repeat (3) @(posedge clk);
    #1; @(negedge clk);
    check("rst_readies", 64'({o_awready, o_wready, o_arready}), 64'(0));
    check("rst_valids", 64'({o_bvalid, o_rvalid}), 64'(0));
    check_regs("rst_regs");
    aresetn = 1'b1; #1;
    check("readies_before_edge", 64'({o_awready, o_wready, o_arready}), 64'(0));
    @(posedge clk); #1; @(negedge clk);
    check("readies_after_edge", 64'({o_awready, o_wready, o_arready}), 64'(3'b111));
    @(posedge clk); #1;

    for (int k = 0; k < 13; k++) begin
      v = vecs[k];
      if (v.wr) begin
        exp_b.push_back(v.resp);
        if (v.pidx >= 0) begin
          model[v.pidx] = v.val;
          exp_pulse[v.pidx]++;
        end
        fork
          begin
            if (v.lead < 0) repeat (-v.lead) begin @(posedge clk); #1; end
            aw_send(v.addr);
          end
          begin
            if (v.lead > 0) repeat (v.lead) begin @(posedge clk); #1; end
            w_send(v.data, v.strb);
          end
        join
        wait_drain("vec_wr");
        check_regs("vec_regs");
        check_pulses("vec_pulses");
      end else begin
        exp_r.push_back({v.val, v.resp});
        ar_send(v.addr);
        wait_drain("vec_rd");
      end
    end

    // B backpressure: second pair waits behind an unaccepted response
    bready = 1'b0;
    exp_b.push_back(2'b00); model[3] = 32'h11111111; exp_pulse[3]++;
    fork aw_send(6'h0C); w_send(32'h11111111, 4'hF); join
    exp_b.push_back(2'b00); exp_pulse[3]++;
    fork aw_send(6'h0C); w_send(32'h22222222, 4'hF); join
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("bp_held", 64'({o_bvalid, o_awready, o_wready}), 64'(3'b100));
      check_regs("bp_regs_hold");
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    model[3] = 32'h22222222;
    check("bp_second_bvalid", 64'(o_bvalid), 64'(1));
    check_regs("bp_second_commit");
    @(posedge clk); #1;
    wait_drain("bp");
    check_pulses("bp_pulses");

    // Read on the commit edge returns the old value; then R stall
    exp_b.push_back(2'b00); model[2] = 32'h0BADCAFE; exp_pulse[2]++;
    fork aw_send(6'h08); w_send(32'h0BADCAFE, 4'hF); join
    wait_drain("col_pre");
    rready = 1'b0;
    exp_b.push_back(2'b00); exp_pulse[2]++;
    fork aw_send(6'h08); w_send(32'hA5A5A5A5, 4'hF); join
    araddr = 6'h08; arvalid = 1'b1;
    exp_r.push_back({32'h0BADCAFE, 2'b00});
    @(negedge clk);
    check("col_arready", 64'(o_arready), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    model[2] = 32'hA5A5A5A5;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("stall_r", 64'({o_rvalid, o_arready, o_rdata}), 64'({1'b1, 1'b0, 32'h0BADCAFE}));
      @(posedge clk); #1;
    end
    check_regs("col_regs");
    rready = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    check("arready_after_r", 64'({o_arready, o_rvalid}), 64'(2'b10));
    @(posedge clk); #1;
    wait_drain("col");
    check_pulses("col_pulses");

    // Reset with an AW latched: latch discarded, no response ever
    aw_send(6'h00);
    aresetn = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (3) begin
      @(posedge clk); #1; @(negedge clk);
      check("mid_rst_state", 64'({o_awready, o_wready, o_arready, o_bvalid}), 64'(0));
    end
    check_regs("mid_rst_regs");
    aresetn = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    check("mid_rst_readies", 64'({o_awready, o_wready, o_arready}), 64'(3'b111));
    @(posedge clk); #1;
    w_send(32'h5A5A5A5A, 4'hF);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_commit", 64'(o_bvalid), 64'(0));
      @(posedge clk); #1;
    end
    check_regs("no_stale_regs");
    exp_b.push_back(2'b00); model[2] = 32'h5A5A5A5A; exp_pulse[2]++;
    aw_send(6'h08);
    wait_drain("post_rst");
    check_regs("post_rst_regs");
    check_pulses("post_rst_pulses");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
